// File: rtl/input_conditioner.sv
// -----------------------------------------------------------------------------
// input_conditioner
//
// Cleans up the raw DE10-Nano push-buttons and slide switches. Each input goes
// through a 2-FF synchronizer and a counter-based debouncer. The block
// provides clean levels, one-cycle key-press pulses, and an event FIFO that
// records every debounced level change for the downstream PIO/controller.
//
// Ports:
//   clk            system clock
//   reset_n        asynchronous active-low reset
//   key[1:0]       raw push-buttons, active-low (0 = pressed)
//   switch[3:0]    raw slide switches, active-high
//   key_clean      debounced keys, active-high (1 = pressed)
//   switch_clean   debounced switches
//   key_press      one-cycle pulse after a debounced key press
//   event_valid    event FIFO is non-empty
//   event_data     head event: [7] source (0 key, 1 switch), [6] new level,
//                  [5:2] zero, [1:0] input index
//   event_ready    consumer accepts the head event
//   overflow       sticky flag: an event was dropped because the FIFO was full
//   clear_overflow synchronous clear of overflow
// -----------------------------------------------------------------------------
module input_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned CNT_W           = 16,
  parameter int unsigned FIFO_DEPTH      = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] key,
  input  logic [3:0] switch,
  output logic [1:0] key_clean,
  output logic [3:0] switch_clean,
  output logic [1:0] key_press,
  output logic       event_valid,
  output logic [7:0] event_data,
  input  logic       event_ready,
  output logic       overflow,
  input  logic       clear_overflow
);

  // Internal input vector, all active-high: [1:0] keys, [5:2] switches.
  // The bit order is also the arbiter priority (bit 0 wins).
  localparam int unsigned NIN    = 6;
  localparam int unsigned N_KEYS = 2;
  localparam int unsigned AW     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [AW:0]      FIFO_FULL = (AW + 1)'(FIFO_DEPTH);

  logic [NIN-1:0]             raw;
  logic [NIN-1:0]             s1_q, s1_d, s2_q, s2_d;
  logic [NIN-1:0]             stable_q, stable_d;
  logic [NIN-1:0][CNT_W-1:0]  cnt_q, cnt_d;
  logic [NIN-1:0]             pending_q, pending_d;
  logic [N_KEYS-1:0]          key_press_q, key_press_d;
  logic [AW-1:0]              wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]                count_q, count_d;
  logic                       overflow_q, overflow_d;
  logic [7:0]                 mem_q [FIFO_DEPTH];

  logic [NIN-1:0]             grant;
  logic [7:0]                 mem_wdata;
  logic                       push, pop, drop, push_ok;

  // Keys are inverted here so everything downstream is active-high.
  assign raw = {switch, ~key};

  // ---------------------------------------------------------------------------
  // Synchronizer + debounce
  // ---------------------------------------------------------------------------
  // NOTE: every signal assigned in an always_comb gets a default at the top of
  // the block, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    s1_d     = raw;
    s2_d     = s1_q;
    stable_d = stable_q;
    cnt_d    = cnt_q;
    for (int i = 0; i < NIN; i++) begin
      if (s2_q[i] == stable_q[i]) begin
        // Any return to the accepted level restarts the hold count.
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_LAST) begin
        stable_d[i] = s2_q[i];
        cnt_d[i]    = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
    key_press_d = stable_d[N_KEYS-1:0] & ~stable_q[N_KEYS-1:0];
  end

  // ---------------------------------------------------------------------------
  // Event arbiter + FIFO control
  // ---------------------------------------------------------------------------
  always_comb begin
    grant     = '0;
    mem_wdata = '0;
    // Walk from the lowest priority upward so the last hit is the winner.
    for (int i = NIN - 1; i >= 0; i--) begin
      if (pending_q[i]) begin
        grant     = '0;
        grant[i]  = 1'b1;
        mem_wdata = {(i >= N_KEYS), stable_q[i], 4'b0000,
                     2'(i >= N_KEYS ? i - N_KEYS : i)};
      end
    end

    push    = |pending_q;
    pop     = event_valid & event_ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    drop    = push & (count_q == FIFO_FULL) & ~pop;
    push_ok = push & ~drop;

    // A dropped event still retires its pending flag.
    pending_d = (pending_q & ~grant) | (stable_d ^ stable_q);
    wr_ptr_d  = wr_ptr_q + AW'(push_ok);
    rd_ptr_d  = rd_ptr_q + AW'(pop);
    count_d   = count_q + (AW + 1)'(push_ok) - (AW + 1)'(pop);

    // A drop in the same cycle as a clear wins: the flag must not lose it.
    if (drop)                overflow_d = 1'b1;
    else if (clear_overflow) overflow_d = 1'b0;
    else                     overflow_d = overflow_q;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_q        <= '0;
      s2_q        <= '0;
      stable_q    <= '0;
      cnt_q       <= '0;
      pending_q   <= '0;
      key_press_q <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
    end else begin
      s1_q        <= s1_d;
      s2_q        <= s2_d;
      stable_q    <= stable_d;
      cnt_q       <= cnt_d;
      pending_q   <= pending_d;
      key_press_q <= key_press_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
    end
  end

  // NOTE: the storage array has no reset; its contents are only observable
  // through entries the pointers mark as valid, and leaving it unreset lets it
  // map onto plain registers or RAM.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= mem_wdata;
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign key_clean    = stable_q[N_KEYS-1:0];
  assign switch_clean = stable_q[NIN-1:N_KEYS];
  assign key_press    = key_press_q;
  assign event_valid  = (count_q != '0);
  // Forced to zero while empty so stale storage never shows on the bus.
  assign event_data   = event_valid ? mem_q[rd_ptr_q] : 8'h00;
  assign overflow     = overflow_q;

endmodule

// File: tb/tb_input_conditioner.sv
// -----------------------------------------------------------------------------
// tb_input_conditioner
//
// Self-checking bench for input_conditioner. A reference model works from
// the behavioural rules: an input's clean level flips once its synchronized
// sample has differed from the clean level for DEBOUNCE_CYCLES consecutive
// samples. Changed inputs join a pending set, the lowest index is served
// first, and the FIFO is a queue plus an occupancy count. The model pushes
// expected events into a scoreboard queue. A monitor on the falling edge
// compares the DUT outputs and pops the scoreboard on every handshake.
// -----------------------------------------------------------------------------
module tb_input_conditioner;

  localparam int D     = 4;
  localparam int DEPTH = 8;
  localparam int N     = 6;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [1:0] key;
  logic [3:0] switch;
  logic [1:0] key_clean;
  logic [3:0] switch_clean;
  logic [1:0] key_press;
  logic       event_valid;
  logic [7:0] event_data;
  logic       event_ready;
  logic       overflow;
  logic       clear_overflow;

  input_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .CNT_W          (4),
    .FIFO_DEPTH     (DEPTH)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .key           (key),
    .switch        (switch),
    .key_clean     (key_clean),
    .switch_clean  (switch_clean),
    .key_press     (key_press),
    .event_valid   (event_valid),
    .event_data    (event_data),
    .event_ready   (event_ready),
    .overflow      (overflow),
    .clear_overflow(clear_overflow)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Check bookkeeping
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic flag_fail(input string name, input logic [31:0] act);
    n_checks++;
    $display("FAIL %s: got 0x%0h, want no event (t=%0t)", name, act, $time);
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  logic [N-1:0] m_stable;
  logic [N-1:0] m_pending;
  logic [1:0]   m_kp;
  logic         m_ovf;
  int           m_cnt;
  logic [N-1:0] hist [D+1];   // hist[k] = raw input seen k+1 edges ago
  logic [7:0]   exp_q [$];

  function automatic logic [7:0] ev_code(input int idx, input logic lvl);
    int v;
    v = (idx < 2) ? idx : (128 + idx - 2);
    if (lvl) v = v + 64;
    return 8'(v);
  endfunction

  task automatic model_reset();
    m_stable  = '0;
    m_pending = '0;
    m_kp      = '0;
    m_ovf     = 1'b0;
    m_cnt     = 0;
    for (int k = 0; k <= D; k++) hist[k] = '0;
    exp_q.delete();
  endtask

  task automatic model_step();
    logic [N-1:0] raw_now;
    logic [N-1:0] flips;
    logic         pop, drop, held;
    int           g;
    raw_now = {switch, ~key};
    pop     = event_ready && (m_cnt > 0);
    drop    = 1'b0;
    g       = -1;
    for (int i = 0; i < N; i++) if (m_pending[i] && g < 0) g = i;
    if (g >= 0) begin
      m_pending[g] = 1'b0;
      if (m_cnt == DEPTH && !pop) drop = 1'b1;
      else begin
        exp_q.push_back(ev_code(g, m_stable[g]));
        m_cnt++;
      end
    end
    if (drop) m_ovf = 1'b1;
    else if (clear_overflow) m_ovf = 1'b0;
    if (pop) m_cnt--;
    // Synchronized sample used at this edge is two edges old: hist[1..D].
    for (int i = 0; i < N; i++) begin
      held = 1'b1;
      for (int k = 1; k <= D; k++) if (hist[k][i] == m_stable[i]) held = 1'b0;
      flips[i] = held;
    end
    m_kp      = flips[1:0] & ~m_stable[1:0];
    m_stable  = m_stable ^ flips;
    m_pending = m_pending | flips;
    for (int k = D; k >= 1; k--) hist[k] = hist[k-1];
    hist[0] = raw_now;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) model_reset();
      else model_step();
    end
  end

  // ---------------------------------------------------------------------------
  // Monitor / scoreboard
  // ---------------------------------------------------------------------------
  logic [7:0] pop_log [$];
  int         kp1_cnt;

  initial begin
    forever begin
      @(negedge clk);
      check("key_clean",    key_clean,    m_stable[1:0]);
      check("switch_clean", switch_clean, m_stable[5:2]);
      check("key_press",    key_press,    m_kp);
      check("overflow",     overflow,     m_ovf);
      check("event_valid",  event_valid,  m_cnt != 0);
      if (key_press[1]) kp1_cnt++;
      if (event_valid) begin
        if (exp_q.size() == 0) flag_fail("event_unexpected", event_data);
        else begin
          check("event_data", event_data, exp_q[0]);
          if (event_ready) begin
            void'(exp_q.pop_front());
            pop_log.push_back(event_data);
          end
        end
      end else begin
        check("event_data_idle", event_data, 8'h00);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] seq4 [5];
    logic [7:0] seq5 [8];
    logic [N-1:0] raw_drv;
    seq4 = '{8'h40, 8'hC0, 8'hC1, 8'hC2, 8'hC3};
    seq5 = '{8'h40, 8'h41, 8'hC0, 8'hC1, 8'hC2, 8'hC3, 8'h00, 8'h01};
    kp1_cnt        = 0;
    reset_n        = 1'b0;
    key            = 2'b11;
    switch         = 4'h0;
    event_ready    = 1'b0;
    clear_overflow = 1'b0;

    // Reset and idle
    tick(3);
    check("rst_key_clean",   key_clean,    2'b00);
    check("rst_switch",      switch_clean, 4'h0);
    check("rst_event_valid", event_valid,  1'b0);
    check("rst_event_data",  event_data,   8'h00);
    check("rst_overflow",    overflow,     1'b0);
    reset_n = 1'b1;
    tick(20);
    check("idle_event_valid", event_valid, 1'b0);

    // Clean press of key[0]
    event_ready = 1'b1;
    key[0] = 1'b0;                      // edge 0
    tick(5);
    check("k0_clean_e5", key_clean, 2'b00);
    tick(1);
    check("k0_clean_e6", key_clean, 2'b01);
    check("k0_press_e6", key_press, 2'b01);
    tick(1);
    check("k0_press_e7", key_press, 2'b00);
    check("k0_valid_e7", event_valid, 1'b1);
    check("k0_data_e7",  event_data, 8'h40);
    tick(6);
    pop_log.delete();
    key[0] = 1'b1;
    tick(12);
    check("k0_rel_count", pop_log.size(), 1);
    if (pop_log.size() > 0) check("k0_rel_data", pop_log[0], 8'h00);

    // Bouncing key[1], then a clean hold
    pop_log.delete();
    kp1_cnt = 0;
    for (int k = 0; k < 10; k++) begin
      key[1] = ~key[1];
      tick(2);
    end
    key[1] = 1'b0;
    tick(12);
    check("k1_event_count", pop_log.size(), 1);
    if (pop_log.size() > 0) check("k1_event_data", pop_log[0], 8'h41);
    check("k1_press_count", kp1_cnt, 1);
    key[1] = 1'b1;
    tick(12);

    // Simultaneous changes, consumer stalled: ordering and head hold
    event_ready = 1'b0;
    switch = 4'hF;
    key[0] = 1'b0;
    tick(9);
    check("ord_head_hold_a", event_data, 8'h40);
    tick(6);
    check("ord_head_hold_b", event_data, 8'h40);
    check("ord_valid_held",  event_valid, 1'b1);
    pop_log.delete();
    event_ready = 1'b1;
    tick(10);
    check("ord_count", pop_log.size(), 5);
    for (int i = 0; i < 5; i++)
      if (i < pop_log.size()) check("ord_data", pop_log[i], seq4[i]);
    switch = 4'h0;
    key    = 2'b11;
    tick(16);

    // Overflow: 12 events into an 8-entry FIFO with the consumer stalled
    event_ready = 1'b0;
    key    = 2'b00;
    switch = 4'hF;
    tick(10);
    key    = 2'b11;
    switch = 4'h0;
    tick(15);
    check("ovf_set",   overflow,    1'b1);
    check("ovf_valid", event_valid, 1'b1);
    pop_log.delete();
    event_ready = 1'b1;
    tick(12);
    check("ovf_drain_count", pop_log.size(), 8);
    for (int i = 0; i < 8; i++)
      if (i < pop_log.size()) check("ovf_drain_data", pop_log[i], seq5[i]);
    check("ovf_sticky", overflow, 1'b1);
    clear_overflow = 1'b1;
    tick(1);
    clear_overflow = 1'b0;
    check("ovf_cleared", overflow, 1'b0);

    // Reset in the middle of a switch[2] debounce
    event_ready = 1'b0;
    switch[2] = 1'b1;
    tick(4);
    reset_n = 1'b0;
    #1;
    check("mid_rst_valid",  event_valid,  1'b0);
    check("mid_rst_switch", switch_clean, 4'h0);
    tick(2);
    reset_n = 1'b1;                     // edge 0 after release
    tick(D + 2);
    check("mid_rst_valid_early", event_valid, 1'b0);
    tick(1);
    check("mid_rst_valid_e7", event_valid, 1'b1);
    check("mid_rst_data_e7",  event_data,  8'hC2);
    pop_log.delete();
    event_ready = 1'b1;
    tick(4);
    check("mid_rst_count", pop_log.size(), 1);
    switch = 4'h0;
    tick(12);

    // Randomized traffic with stall windows, clears and a reset pulse
    raw_drv = {switch, ~key};
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < N; b++)
        if ($urandom_range(0, 11) == 0) raw_drv[b] = ~raw_drv[b];
      key            = ~raw_drv[1:0];
      switch         = raw_drv[5:2];
      event_ready    = ((c % 300) < 200) ? ($urandom_range(0, 2) != 0) : 1'b0;
      clear_overflow = ($urandom_range(0, 63) == 0);
      if (c == 1500) reset_n = 1'b0;
      if (c == 1503) reset_n = 1'b1;
      tick(1);
    end
    clear_overflow = 1'b0;
    event_ready    = 1'b1;
    tick(60);
    check("final_valid", event_valid, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
